// File: rtl/enc_pkg.sv
// Shared types and constants for the round-robin 16-to-4 request encoder.
package enc_pkg;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  typedef enum logic {IDLE, OFFER} enc_state_t;

  typedef logic [W-1:0] idx_t;

  function automatic logic [N-1:0] onehot(idx_t i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 16.
module rr_pick16
  import enc_pkg::*;
(
  input  logic [N-1:0] req,
  input  idx_t         ptr,
  output idx_t         win,
  output logic         any
);

  logic [N-1:0] rot;
  idx_t         idx;

  // Rotate right by ptr so the priority start lands on bit 0; the 4-bit sum wraps naturally.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[idx_t'(i) + ptr];
    end
  end

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = idx_t'(i);
    end
  end

  assign win = idx + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_encoder16_to4.sv
// Round-robin 16-to-4 request encoder offering the winner's index over valid/ready.
module rr_encoder16_to4
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output idx_t         code,
  output logic [N-1:0] grant
);

  enc_state_t   state_q;
  idx_t         ptr_q;
  logic         valid_q;
  idx_t         code_q;
  logic [N-1:0] grant_q;

  logic accept;
  idx_t pick_ptr;
  idx_t win;
  logic any;

  assign accept = (state_q == OFFER) && ready;

  // On accept the re-pick must already see the advanced pointer.
  assign pick_ptr = accept ? idx_t'(code_q + idx_t'(1)) : ptr_q;

  rr_pick16 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win),
    .any (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      grant_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en && any) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            code_q  <= win;
            grant_q <= onehot(win);
          end
        end
        OFFER: begin
          if (ready) begin
            ptr_q <= pick_ptr;
            if (en && any) begin
              code_q  <= win;
              grant_q <= onehot(win);
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign code  = code_q;
  assign grant = grant_q;

endmodule
